// File: rtl/kempston_mouse_port.sv
// Kempston mouse port: turns PS/2 decoder counters into scaled X/Y accumulators,
// a 4-bit wheel count and an active-low button byte, served on one-cycle read strobes.
module kempston_mouse_port (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] xcount_i,
    input  logic [7:0] ycount_i,
    input  logic [7:0] zcount_i,
    input  logic       mleft_i,
    input  logic       mright_i,
    input  logic       mthird_i,
    input  logic       enable_i,
    input  logic [1:0] dpi_i,
    input  logic       swap_i,
    input  logic       port_rd_i,
    input  logic [1:0] port_sel_i,
    output logic [7:0] port_dout_o,
    output logic       port_valid_o
);

    logic [7:0] r_xprev;
    logic [7:0] r_yprev;
    logic [7:0] r_zprev;
    logic [9:0] r_xacc;
    logic [9:0] r_yacc;
    logic [3:0] r_wacc;
    logic       r_left;
    logic       r_right;
    logic       r_mid;

    logic [7:0] w_dx;
    logic [7:0] w_dy;
    logic [7:0] w_dz;
    logic [9:0] w_xinc;
    logic [9:0] w_yinc;
    logic       w_btnL;
    logic       w_btnR;
    logic [7:0] w_btnByte;
    logic [7:0] w_rdData;

    // Sign-extend the 8-bit delta into the 10-bit accumulator domain (2 fraction
    // bits), then shift by 1..4 so that dpi 00 yields half a count per step.
    function automatic logic [9:0] scaleDelta(input logic [7:0] d, input logic [1:0] dpi);
        logic [9:0] ext;
        logic [9:0] res;
        ext = {{2{d[7]}}, d};
        case (dpi)
            2'b00:   res = ext << 1;
            2'b01:   res = ext << 2;
            2'b10:   res = ext << 3;
            default: res = ext << 4;
        endcase
        return res;
    endfunction

    // Previous samples track the inputs even in reset, so the first cycle out of
    // reset sees a zero delta.
    always_ff @(posedge clk) begin
        r_xprev <= xcount_i;
        r_yprev <= ycount_i;
        r_zprev <= zcount_i;
    end

    assign w_dx   = xcount_i - r_xprev;
    assign w_dy   = ycount_i - r_yprev;
    assign w_dz   = zcount_i - r_zprev;
    assign w_xinc = scaleDelta(w_dx, dpi_i);
    assign w_yinc = scaleDelta(w_dy, dpi_i);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_xacc <= 10'd0;
            r_yacc <= 10'd0;
            r_wacc <= 4'd0;
        end else if (enable_i) begin
            r_xacc <= r_xacc + w_xinc;
            r_yacc <= r_yacc + w_yinc;
            r_wacc <= r_wacc + w_dz[3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_left  <= 1'b0;
            r_right <= 1'b0;
            r_mid   <= 1'b0;
        end else begin
            r_left  <= mleft_i;
            r_right <= mright_i;
            r_mid   <= mthird_i;
        end
    end

    assign w_btnL    = swap_i ? r_right : r_left;
    assign w_btnR    = swap_i ? r_left  : r_right;
    assign w_btnByte = {r_wacc, 1'b1, ~r_mid, ~w_btnL, ~w_btnR};

    always_comb begin
        w_rdData = 8'hFF;
        case (port_sel_i)
            2'b00:   w_rdData = w_btnByte;
            2'b01:   w_rdData = r_xacc[9:2];
            2'b10:   w_rdData = r_yacc[9:2];
            default: w_rdData = 8'hFF;
        endcase
    end

    // Read data is captured from pre-update register values; reset masks strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            port_dout_o  <= 8'h00;
            port_valid_o <= 1'b0;
        end else begin
            port_valid_o <= port_rd_i;
            if (port_rd_i) begin
                port_dout_o <= w_rdData;
            end
        end
    end

endmodule
